// File: rtl/snn_layer_engine_if.sv
// Weight memory channels of snn_layer_engine: a read channel (request,
// address, valid/data return) and a write channel (request held until ack).
interface snn_layer_engine_if #(
  parameter int ADDR_W = 4,
  parameter int WW     = 4
);
  logic              w_req;
  logic [ADDR_W-1:0] w_addr;
  logic              w_valid;
  logic [WW-1:0]     w_data;
  logic              wb_req;
  logic [ADDR_W-1:0] wb_addr;
  logic [WW-1:0]     wb_wdata;
  logic              wb_ack;

  modport master (
    output w_req, w_addr, wb_req, wb_addr, wb_wdata,
    input  w_valid, w_data, wb_ack
  );

  modport slave (
    input  w_req, w_addr, wb_req, wb_addr, wb_wdata,
    output w_valid, w_data, wb_ack
  );
endinterface

// File: rtl/snn_layer_engine.sv
// Parametrised spiking layer: N_OUT neuron sums from N_IN latched inputs
// using signed shift-weights fetched one at a time, argmax winner selection
// and an optional reward-driven saturating update of the winner's weights.
module snn_layer_engine #(
  parameter int N_IN   = 4,
  parameter int N_OUT  = 2,
  parameter int DW     = 8,
  parameter int WW     = 4,
  parameter int ADDR_W = 4,
  parameter int TH     = 1
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    start,
  input  logic [N_IN*DW-1:0]                      in_vec,
  input  logic                                    learn_en,
  input  logic [1:0]                              reward,
  snn_layer_engine_if.master                      wmem,
  output logic [N_OUT*DW-1:0]                     out_vec,
  output logic [$clog2(N_OUT > 1 ? N_OUT : 2)-1:0] winner,
  output logic                                    busy,
  output logic                                    done
);

  localparam int IW = $clog2(N_IN > 1 ? N_IN : 2);
  localparam int OW = $clog2(N_OUT > 1 ? N_OUT : 2);
  localparam logic [DW-1:0] TH_V  = DW'(TH);
  localparam logic [WW-1:0] W_MAX = {1'b0, {(WW-1){1'b1}}};
  localparam logic [WW-1:0] W_MIN = {1'b1, {(WW-1){1'b0}}};
  localparam logic [IW:0]   NONE  = (IW+1)'(N_IN);

  typedef enum logic [2:0] {
    IDLE, REQ, WAIT, ARG, L_REQ, L_WAIT, L_WR, DONE
  } state_t;

  state_t state, state_nxt;

  logic [N_IN*DW-1:0]  x_q;
  logic                learn_q;
  logic [1:0]          rew_q;
  logic [DW-1:0]       acc [N_OUT];
  logic [OW-1:0]       oi;
  logic [IW-1:0]       ii;
  logic [IW-1:0]       li;
  logic [OW-1:0]       win_q;
  logic [N_OUT*DW-1:0] out_q;
  logic [ADDR_W-1:0]   wb_addr_q;
  logic [WW-1:0]       wb_wdata_q;

  logic [DW-1:0]       x_cur;
  logic [DW-1:0]       term;
  logic [DW-1:0]       acc_sum;
  logic [DW:0]         sum_wide;
  logic [WW:0]         neg_amt;
  logic                last_i;
  logic                last_o;
  logic [ADDR_W-1:0]   cmp_addr;
  logic [ADDR_W-1:0]   lrn_addr;
  logic [IW:0]         first_act;
  logic [IW:0]         nxt_act;
  logic [OW-1:0]       best_idx;
  logic [DW-1:0]       best_val;
  logic [WW-1:0]       new_w;
  logic                rew_nz;

  // Lowest input index >= from whose value is above threshold, NONE if none.
  // Lets the learning loop jump straight over silent inputs.
  function automatic logic [IW:0] find_act(input int unsigned from,
                                           input logic [N_IN*DW-1:0] v);
    logic [IW:0] r;
    r = NONE;
    for (int unsigned k = N_IN; k > 0; k--) begin
      if ((k - 1) >= from && v[(k-1)*DW +: DW] > TH_V) r = (IW+1)'(k - 1);
    end
    return r;
  endfunction

  // Datapath: shift term, saturating accumulate, addresses, argmax, weight update
  always_comb begin
    x_cur   = x_q[ii*DW +: DW];
    neg_amt = '0 - {wmem.w_data[WW-1], wmem.w_data};
    term    = '0;
    if (x_cur > TH_V) begin
      term = wmem.w_data[WW-1] ? (x_cur >> neg_amt) : (x_cur << wmem.w_data);
    end
    sum_wide = {1'b0, acc[oi]} + {1'b0, term};
    acc_sum  = sum_wide[DW] ? '1 : sum_wide[DW-1:0];

    cmp_addr = ADDR_W'(oi) * ADDR_W'(N_IN) + ADDR_W'(ii);
    lrn_addr = ADDR_W'(win_q) * ADDR_W'(N_IN) + ADDR_W'(li);
    last_i   = (ii == IW'(N_IN - 1));
    last_o   = (oi == OW'(N_OUT - 1));

    first_act = find_act(0, x_q);
    nxt_act   = find_act(32'(li) + 32'd1, x_q);

    best_idx = '0;
    best_val = acc[0];
    for (int unsigned k = 1; k < N_OUT; k++) begin
      if (acc[k] > best_val) begin
        best_val = acc[k];
        best_idx = OW'(k);
      end
    end

    rew_nz = (rew_q != 2'b00);
    if (rew_q[1]) new_w = (wmem.w_data == W_MIN) ? wmem.w_data : wmem.w_data - 1'b1;
    else          new_w = (wmem.w_data == W_MAX) ? wmem.w_data : wmem.w_data + 1'b1;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and handshake outputs
  always_comb begin
    state_nxt     = state;
    wmem.w_req    = 1'b0;
    wmem.w_addr   = '0;
    wmem.wb_req   = 1'b0;
    busy          = (state != IDLE);
    done          = 1'b0;
    unique case (state)
      IDLE:   if (start) state_nxt = REQ;
      REQ: begin
        wmem.w_req  = 1'b1;
        wmem.w_addr = cmp_addr;
        state_nxt   = WAIT;
      end
      WAIT:   if (wmem.w_valid) state_nxt = (last_i && last_o) ? ARG : REQ;
      ARG:    state_nxt = (learn_q && rew_nz && first_act != NONE) ? L_REQ : DONE;
      L_REQ: begin
        wmem.w_req  = 1'b1;
        wmem.w_addr = lrn_addr;
        state_nxt   = L_WAIT;
      end
      L_WAIT: if (wmem.w_valid) state_nxt = L_WR;
      L_WR: begin
        wmem.wb_req = 1'b1;
        if (wmem.wb_ack) state_nxt = (nxt_act == NONE) ? DONE : L_REQ;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch, accumulators, result registers and write-channel holding regs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_q        <= '0;
      learn_q    <= 1'b0;
      rew_q      <= '0;
      oi         <= '0;
      ii         <= '0;
      li         <= '0;
      win_q      <= '0;
      out_q      <= '0;
      wb_addr_q  <= '0;
      wb_wdata_q <= '0;
      for (int unsigned k = 0; k < N_OUT; k++) acc[k] <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          x_q     <= in_vec;
          learn_q <= learn_en;
          rew_q   <= reward;
          oi      <= '0;
          ii      <= '0;
          for (int unsigned k = 0; k < N_OUT; k++) acc[k] <= '0;
        end
        WAIT: if (wmem.w_valid) begin
          acc[oi] <= acc_sum;
          if (last_i) begin
            ii <= '0;
            oi <= oi + 1'b1;
          end else begin
            ii <= ii + 1'b1;
          end
        end
        ARG: begin
          for (int unsigned k = 0; k < N_OUT; k++) out_q[k*DW +: DW] <= acc[k];
          win_q <= best_idx;
          li    <= first_act[IW-1:0];
        end
        L_WAIT: if (wmem.w_valid) begin
          wb_addr_q  <= lrn_addr;
          wb_wdata_q <= new_w;
        end
        L_WR: if (wmem.wb_ack && nxt_act != NONE) li <= nxt_act[IW-1:0];
        default: ;
      endcase
    end
  end

  assign wmem.wb_addr  = wb_addr_q;
  assign wmem.wb_wdata = wb_wdata_q;
  assign out_vec       = out_q;
  assign winner        = win_q;

endmodule

// File: tb/tb_snn_layer_engine.sv
// Directed bench for snn_layer_engine with a behavioural weight memory
// (read responder with optional delay/stray valid, write acknowledger).
module tb_snn_layer_engine;
  localparam int N_IN = 4, N_OUT = 2, DW = 8, WW = 4, ADDR_W = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic                learn_en = 1'b0;
  logic [1:0]          reward = '0;
  logic [N_IN*DW-1:0]  in_vec = '0;
  logic [N_OUT*DW-1:0] out_vec;
  logic [0:0]          winner;
  logic                busy, done;

  int n_vec = 0, n_err = 0, cyc = 0, overlap = 0, last_ack_cyc = 0;
  logic [WW-1:0] mem [16];
  int rd_log[$], wr_addr[$], wr_data[$];
  bit rd_rand = 0, stray_en = 0;
  logic rsp_valid = 1'b0, stray_valid = 1'b0, wb_ack_r = 1'b0;
  logic [WW-1:0] rsp_data = '0, stray_data = '0;

  snn_layer_engine_if #(.ADDR_W(ADDR_W), .WW(WW)) mem_if ();

  assign mem_if.w_valid = rsp_valid | stray_valid;
  assign mem_if.w_data  = stray_valid ? stray_data : rsp_data;
  assign mem_if.wb_ack  = wb_ack_r;

  snn_layer_engine #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .WW(WW), .ADDR_W(ADDR_W), .TH(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_vec(in_vec), .learn_en(learn_en),
    .reward(reward), .wmem(mem_if), .out_vec(out_vec), .winner(winner), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Read responder: data one cycle after the request plus an optional extra delay
  initial begin : rd_resp
    int d;
    logic [ADDR_W-1:0] a;
    forever begin
      @(negedge clk);
      if (mem_if.w_req) begin
        a = mem_if.w_addr;
        rd_log.push_back(int'(a));
        d = rd_rand ? int'($urandom_range(0, 3)) : 0;
        if (stray_en && $urandom_range(0, 1) == 1) begin
          rsp_data  = 4'h7;
          rsp_valid = 1'b1;
        end
        @(posedge clk); #1;
        rsp_valid = 1'b0;
        repeat (d) begin @(posedge clk); #1; end
        rsp_data  = mem[a];
        rsp_valid = 1'b1;
        @(posedge clk); #1;
        rsp_valid = 1'b0;
      end
    end
  end

  // Write acknowledger: ack one cycle after the request appears
  initial begin : wr_resp
    forever begin
      @(negedge clk);
      if (mem_if.wb_req) begin
        @(posedge clk); #1; wb_ack_r = 1'b1;
        @(posedge clk); #1; wb_ack_r = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (mem_if.wb_req && mem_if.wb_ack) begin
      wr_addr.push_back(int'(mem_if.wb_addr));
      wr_data.push_back(int'(mem_if.wb_wdata));
      last_ack_cyc = cyc;
    end
    if (mem_if.w_req && mem_if.wb_req) overlap++;
  end

  task automatic load_mem(input logic [8*WW-1:0] w);
    for (int k = 0; k < 16; k++) mem[k] = (k < 8) ? w[k*WW +: WW] : '0;
  endtask

  task automatic run_op(input logic [N_IN*DW-1:0] x, input logic le, input logic [1:0] rw,
                        input bit mid_start, output int lat);
    int s;
    in_vec = x; learn_en = le; reward = rw;
    @(posedge clk); #1; start = 1'b1; s = cyc;
    @(posedge clk); #1; start = 1'b0;
    in_vec = '0; learn_en = 1'b0; reward = '0;
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL busy_after_start: got %b expected 1", busy); end
    if (mid_start) begin
      @(posedge clk); #1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
    end
    lat = -1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done) begin lat = cyc - s; break; end
    end
    n_vec++;
    if (lat < 0) begin n_err++; $display("FAIL done_timeout: got no done expected done within 300 cycles"); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({busy, done, mem_if.w_req, mem_if.wb_req} !== 4'b0000) begin
      n_err++; $display("FAIL reset_ctrl: got %b expected 0000", {busy, done, mem_if.w_req, mem_if.wb_req});
    end
    n_vec++;
    if ({mem_if.w_addr, mem_if.wb_addr, mem_if.wb_wdata} !== '0) begin
      n_err++; $display("FAIL reset_bus: got %h expected 0", {mem_if.w_addr, mem_if.wb_addr, mem_if.wb_wdata});
    end
    n_vec++;
    if ({out_vec, winner} !== '0) begin
      n_err++; $display("FAIL reset_result: got %h expected 0", {out_vec, winner});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat, rb, wb, ob;
    load_mem(32'hE200_0F21);
    rb = rd_log.size(); wb = wr_addr.size(); ob = overlap;
    run_op(32'h0205_0003, 1'b0, 2'b00, 1'b0, lat);
    n_vec++; if (lat !== 18) begin n_err++; $display("FAIL basic_latency: got %0d expected 18", lat); end
    n_vec++; if (out_vec[7:0] !== 8'd10) begin n_err++; $display("FAIL basic_sum0: got %0d expected 10", out_vec[7:0]); end
    n_vec++; if (out_vec[15:8] !== 8'd23) begin n_err++; $display("FAIL basic_sum1: got %0d expected 23", out_vec[15:8]); end
    n_vec++; if (winner !== 1'b1) begin n_err++; $display("FAIL basic_winner: got %0d expected 1", winner); end
    n_vec++; if (wr_addr.size() - wb !== 0) begin n_err++; $display("FAIL basic_no_write: got %0d writes expected 0", wr_addr.size() - wb); end
    n_vec++; if (rd_log.size() - rb !== 8) begin n_err++; $display("FAIL basic_read_count: got %0d expected 8", rd_log.size() - rb); end
    for (int k = 0; k < 8; k++) begin
      if (rb + k < rd_log.size()) begin
        n_vec++;
        if (rd_log[rb+k] !== k) begin n_err++; $display("FAIL basic_read_addr%0d: got %0d expected %0d", k, rd_log[rb+k], k); end
      end
    end
    @(negedge clk);
    n_vec++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL basic_idle_after: got %b expected 00", {busy, done}); end
    n_vec++; if (overlap !== ob) begin n_err++; $display("FAIL basic_overlap: got %0d expected %0d", overlap, ob); end
  endtask

  task automatic test_learn();
    int lat, wb, ob;
    int ea[3] = '{4, 6, 7};
    int ed[3] = '{1, 3, 15};
    load_mem(32'hE200_0F21);
    wb = wr_addr.size(); ob = overlap;
    run_op(32'h0205_0003, 1'b1, 2'b01, 1'b0, lat);
    n_vec++; if (lat !== 30) begin n_err++; $display("FAIL learn_latency: got %0d expected 30", lat); end
    n_vec++; if (cyc - 1 !== last_ack_cyc) begin n_err++; $display("FAIL learn_done_after_ack: got ack at %0d expected %0d", last_ack_cyc, cyc - 1); end
    n_vec++; if ({out_vec, winner} !== {8'd23, 8'd10, 1'b1}) begin n_err++; $display("FAIL learn_result: got %h expected %h", {out_vec, winner}, {8'd23, 8'd10, 1'b1}); end
    n_vec++; if (wr_addr.size() - wb !== 3) begin n_err++; $display("FAIL learn_write_count: got %0d expected 3", wr_addr.size() - wb); end
    for (int k = 0; k < 3; k++) begin
      if (wb + k < wr_addr.size()) begin
        n_vec++;
        if (wr_addr[wb+k] !== ea[k] || wr_data[wb+k] !== ed[k]) begin
          n_err++; $display("FAIL learn_write%0d: got (%0d,%0d) expected (%0d,%0d)", k, wr_addr[wb+k], wr_data[wb+k], ea[k], ed[k]);
        end
      end
    end
    n_vec++; if (overlap !== ob) begin n_err++; $display("FAIL learn_overlap: got %0d expected %0d", overlap, ob); end
    repeat (3) @(negedge clk);
    n_vec++; if ({out_vec, winner} !== {8'd23, 8'd10, 1'b1}) begin n_err++; $display("FAIL learn_hold: got %h expected %h", {out_vec, winner}, {8'd23, 8'd10, 1'b1}); end
  endtask

  task automatic test_weight_sat();
    int lat, wb;
    load_mem(32'h0007_0000);
    wb = wr_addr.size();
    run_op(32'h0000_0003, 1'b1, 2'b01, 1'b0, lat);
    n_vec++; if (lat !== 22) begin n_err++; $display("FAIL wsat_hi_latency: got %0d expected 22", lat); end
    n_vec++; if ({out_vec, winner} !== {8'd128, 8'd3, 1'b1}) begin n_err++; $display("FAIL wsat_hi_result: got %h expected %h", {out_vec, winner}, {8'd128, 8'd3, 1'b1}); end
    n_vec++;
    if (wr_addr.size() - wb !== 1 || wr_addr[wr_addr.size()-1] !== 4 || wr_data[wr_data.size()-1] !== 7) begin
      n_err++; $display("FAIL wsat_hi_write: got %0d writes last (%0d,%0d) expected 1 write (4,7)", wr_addr.size() - wb, wr_addr[wr_addr.size()-1], wr_data[wr_data.size()-1]);
    end
    load_mem(32'h0008_0008);
    wb = wr_addr.size();
    run_op(32'h0000_0003, 1'b1, 2'b10, 1'b0, lat);
    n_vec++; if (lat !== 22) begin n_err++; $display("FAIL wsat_lo_latency: got %0d expected 22", lat); end
    n_vec++; if ({out_vec, winner} !== 17'd0) begin n_err++; $display("FAIL wsat_lo_result: got %h expected 0", {out_vec, winner}); end
    n_vec++;
    if (wr_addr.size() - wb !== 1 || wr_addr[wr_addr.size()-1] !== 0 || wr_data[wr_data.size()-1] !== 8) begin
      n_err++; $display("FAIL wsat_lo_write: got %0d writes last (%0d,%0d) expected 1 write (0,8)", wr_addr.size() - wb, wr_addr[wr_addr.size()-1], wr_data[wr_data.size()-1]);
    end
  endtask

  task automatic test_sum_sat();
    int lat;
    load_mem(32'h3333_3333);
    run_op(32'hFFFF_FFFF, 1'b0, 2'b00, 1'b0, lat);
    n_vec++; if (lat !== 18) begin n_err++; $display("FAIL ssat_latency: got %0d expected 18", lat); end
    n_vec++; if (out_vec !== 16'hFFFF) begin n_err++; $display("FAIL ssat_sums: got %h expected ffff", out_vec); end
    n_vec++; if (winner !== 1'b0) begin n_err++; $display("FAIL ssat_winner_tie: got %0d expected 0", winner); end
  endtask

  task automatic test_back_to_back();
    int lat, rb;
    load_mem(32'hE200_0F21);
    rd_rand = 1; stray_en = 1;
    @(posedge clk); #1; stray_data = 4'h7; stray_valid = 1'b1;
    @(posedge clk); #1; stray_valid = 1'b0;
    rb = rd_log.size();
    run_op(32'h0205_0003, 1'b0, 2'b00, 1'b1, lat);
    n_vec++; if ({out_vec, winner} !== {8'd23, 8'd10, 1'b1}) begin n_err++; $display("FAIL delay_result: got %h expected %h", {out_vec, winner}, {8'd23, 8'd10, 1'b1}); end
    n_vec++; if (rd_log.size() - rb !== 8) begin n_err++; $display("FAIL delay_read_count: got %0d expected 8", rd_log.size() - rb); end
    repeat (3) @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL busy_start_ignored: got %b expected 0", busy); end
    rd_rand = 0; stray_en = 0;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_reset_mid();
    int lat, wb, reqs;
    bit got;
    load_mem(32'hE200_0F21);
    in_vec = 32'h0205_0003;
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if ({busy, done, mem_if.w_req, mem_if.wb_req, out_vec, winner} !== '0) begin
      n_err++; $display("FAIL rst_wait_outputs: got %h expected 0", {busy, done, mem_if.w_req, mem_if.wb_req, out_vec, winner});
    end
    rst_n = 1'b1;
    reqs = 0;
    for (int k = 0; k < 4; k++) begin @(negedge clk); if (mem_if.w_req || busy) reqs++; end
    n_vec++; if (reqs !== 0) begin n_err++; $display("FAIL rst_wait_quiet: got %0d active cycles expected 0", reqs); end

    load_mem(32'hE200_0F21);
    in_vec = 32'h0205_0003; learn_en = 1'b1; reward = 2'b01;
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    got = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (mem_if.wb_req) begin got = 1; break; end
    end
    n_vec++; if (!got) begin n_err++; $display("FAIL rst_lwr_timeout: got no wb_req expected wb_req within 100 cycles"); end
    wb = wr_addr.size();
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if ({busy, done, mem_if.w_req, mem_if.wb_req, mem_if.wb_addr, mem_if.wb_wdata, out_vec, winner} !== '0) begin
      n_err++; $display("FAIL rst_lwr_outputs: got %h expected 0", {busy, done, mem_if.w_req, mem_if.wb_req, mem_if.wb_addr, mem_if.wb_wdata, out_vec, winner});
    end
    rst_n = 1'b1; learn_en = 1'b0; reward = '0;
    repeat (5) @(posedge clk);
    n_vec++; if (wr_addr.size() !== wb) begin n_err++; $display("FAIL rst_lwr_abandoned: got %0d writes expected %0d", wr_addr.size(), wb); end
    run_op(32'h0205_0003, 1'b0, 2'b00, 1'b0, lat);
    n_vec++; if (lat !== 18) begin n_err++; $display("FAIL rst_rerun_latency: got %0d expected 18", lat); end
    n_vec++; if ({out_vec, winner} !== {8'd23, 8'd10, 1'b1}) begin n_err++; $display("FAIL rst_rerun_result: got %h expected %h", {out_vec, winner}, {8'd23, 8'd10, 1'b1}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_learn();
    test_weight_sat();
    test_sum_sat();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
